// File: rtl/beta_mem_responder.sv
// Memory-side responder for the Beta: 1-cycle-latency word RAM plus an I/O page with
// a laser point FIFO, status/control registers and a free-running cycle counter.
module beta_mem_responder #(
  parameter int unsigned AW        = 12,
  parameter int unsigned FAW       = 6,
  parameter              INIT_FILE = ""
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] ma,
  input  logic [31:0] mdout,
  input  logic        mwe,
  output logic [31:0] mdin,
  output logic        irq,
  output logic [31:0] pt_data,
  output logic        pt_valid,
  input  logic        pt_rd
);

  localparam int unsigned DEPTH = 1 << FAW;
  localparam int unsigned RAM_WORDS = 1 << AW;
  localparam int unsigned CW = FAW + 1;

  logic [31:0] ram  [RAM_WORDS];
  logic [31:0] fifo [DEPTH];

  logic           io_sel;
  logic [2:0]     reg_sel;
  logic [AW-1:0]  ram_idx;
  logic           unused_ok;

  assign io_sel    = ma[30];
  assign reg_sel   = ma[4:2];
  assign ram_idx   = ma[AW+1:2];
  assign unused_ok = ^{ma, (INIT_FILE != "")};

  logic [FAW-1:0] wr_ptr, rd_ptr, rd_next;
  logic [CW-1:0]  count, count_next;
  logic [CW-1:0]  lowwat;
  logic           irqen;
  logic           overflow;
  logic [31:0]    cycles;

  logic push_req, pop_ok, push_ok, full, empty;
  logic status_wr, lowwat_wr, irqen_wr, ram_wr;
  logic [31:0] status_word, io_rdata;

  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);
  assign push_req  = mwe & io_sel & (reg_sel == 3'd0);
  assign status_wr = mwe & io_sel & (reg_sel == 3'd1);
  assign lowwat_wr = mwe & io_sel & (reg_sel == 3'd2);
  assign irqen_wr  = mwe & io_sel & (reg_sel == 3'd3);
  assign ram_wr    = mwe & ~io_sel & ~reset;

  // A pop frees a slot in the same edge, so a full FIFO can still take a push.
  assign pop_ok     = pt_rd & pt_valid;
  assign push_ok    = push_req & (~full | pop_ok);
  assign count_next = count + CW'(push_ok) - CW'(pop_ok);
  assign rd_next    = pop_ok ? rd_ptr + FAW'(1) : rd_ptr;

  assign status_word = {13'd0, overflow, empty, full, 16'(count)};

  always_comb begin
    io_rdata = 32'd0;
    case (reg_sel)
      3'd1:    io_rdata = status_word;
      3'd2:    io_rdata = 32'(lowwat);
      3'd3:    io_rdata = 32'(irqen);
      3'd4:    io_rdata = cycles;
      default: io_rdata = 32'd0;
    endcase
  end

  // Storage arrays: no reset so they map onto RAM macros.
  always_ff @(posedge clk) begin
    if (ram_wr) ram[ram_idx] <= mdout;
    if (push_ok && !reset) fifo[wr_ptr] <= mdout;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mdin     <= 32'd0;
      irq      <= 1'b0;
      pt_data  <= 32'd0;
      pt_valid <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      lowwat   <= CW'(DEPTH / 4);
      irqen    <= 1'b0;
      cycles   <= 32'd0;
    end else begin
      mdin   <= io_sel ? io_rdata : ram[ram_idx];
      cycles <= cycles + 32'd1;

      if (push_ok) wr_ptr <= wr_ptr + FAW'(1);
      rd_ptr   <= rd_next;
      count    <= count_next;
      pt_valid <= (count_next != '0);

      // Head register: a push into an otherwise-empty FIFO bypasses the array.
      if (push_ok && count_next == CW'(1)) pt_data <= mdout;
      else                                 pt_data <= fifo[rd_next];

      if (push_req && full && !pop_ok)       overflow <= 1'b1;
      else if (status_wr && mdout[18])       overflow <= 1'b0;

      if (lowwat_wr) lowwat <= mdout[FAW:0];
      if (irqen_wr)  irqen  <= mdout[0];

      irq <= (irqen_wr ? mdout[0] : irqen) & (count_next < (lowwat_wr ? mdout[FAW:0] : lowwat));
    end
  end

endmodule
